// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one Main_ALU between two requesters.
// Requests arrive on valid/ready channels, and ties are broken round-robin.
// The ALU is driven from registered operands.
// The captured result comes back on a valid/ready response channel,
// tagged with the requester ID and an illegal-opcode error flag.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int OPW    = 5,
    parameter int MAX_OP = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [OPW-1:0]   r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [OPW-1:0]   r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,

    output logic [OPW-1:0]   alu_control,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_flag,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_flag,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [OPW-1:0] MAX_OP_V = OPW'(MAX_OP);

    state_t           state_q, state_d;
    logic             last_id_q, last_id_d;
    logic [OPW-1:0]   alu_control_q, alu_control_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_flag_q, rsp_flag_d;
    logic             rsp_err_q, rsp_err_d;

    logic             grant;
    logic             any_valid;
    logic             accept;
    logic             op_illegal;

    // Grant selection: a lone requester wins; on a tie, the one that was not served last wins.
    always_comb begin
        grant = 1'b0;
        if (r0_valid && r1_valid) begin
            grant = ~last_id_q;
        end else if (r1_valid) begin
            grant = 1'b1;
        end
    end

    assign any_valid  = r0_valid | r1_valid;
    assign r0_ready   = (state_q == IDLE) && r0_valid && (grant == 1'b0);
    assign r1_ready   = (state_q == IDLE) && r1_valid && (grant == 1'b1);
    assign accept     = (state_q == IDLE) && any_valid;
    assign op_illegal = (alu_control_q > MAX_OP_V);

    // Next-state logic: every register holds its value unless the current state updates it.
    always_comb begin
        state_d       = state_q;
        last_id_d     = last_id_q;
        alu_control_d = alu_control_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_flag_d    = rsp_flag_q;
        rsp_err_d     = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_control_d = grant ? r1_op : r0_op;
                    alu_a_d       = grant ? r1_a  : r0_a;
                    alu_b_d       = grant ? r1_b  : r0_b;
                    rsp_id_d      = grant;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                // The ALU has had a full cycle to settle from the registered inputs.
                rsp_err_d    = op_illegal;
                rsp_result_d = op_illegal ? '0   : alu_out;
                rsp_flag_d   = op_illegal ? 1'b0 : alu_flag;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_id_d   = rsp_id_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset. Reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_id_q     <= 1'b1;
            alu_control_q <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flag_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_id_q     <= last_id_d;
            alu_control_q <= alu_control_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flag_q    <= rsp_flag_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign alu_control = alu_control_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_flag    = rsp_flag_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter.
// A small behavioural ALU sits in place of Main_ALU.
// Expected responses are hand-computed constants.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [4:0]  r0_op, r1_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [4:0]  alu_control;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_flag;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_flag, rsp_err, busy;
    logic [31:0] rsp_result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .r0_valid   (r0_valid),
        .r0_ready   (r0_ready),
        .r0_op      (r0_op),
        .r0_a       (r0_a),
        .r0_b       (r0_b),
        .r1_valid   (r1_valid),
        .r1_ready   (r1_ready),
        .r1_op      (r1_op),
        .r1_a       (r1_a),
        .r1_b       (r1_b),
        .alu_control(alu_control),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_flag   (alu_flag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flag   (rsp_flag),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    // Stand-in combinational ALU. Unlisted opcodes return A|B with flag 1,
    // so a missing error mask shows up in the response.
    always_comb begin
        alu_out  = alu_a | alu_b;
        alu_flag = 1'b1;
        case (alu_control)
            5'd0:  {alu_flag, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            5'd1:  begin alu_out = alu_a - alu_b; alu_flag = (alu_a == alu_b); end
            5'd2:  begin alu_out = alu_a & alu_b; alu_flag = 1'b0; end
            5'd3:  begin
                       alu_out  = {31'd0, ($signed(alu_a) < $signed(alu_b))};
                       alu_flag = ($signed(alu_a) < $signed(alu_b));
                   end
            5'd4:  begin alu_out = alu_a ^ alu_b; alu_flag = ((alu_a ^ alu_b) == 32'd0); end
            5'd16: begin alu_out = alu_a >> alu_b[4:0]; alu_flag = (alu_a > alu_b); end
            default: ;
        endcase
    end

    typedef struct {
        logic        req;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        flag;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (req) begin
            r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b;
        end else begin
            r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b;
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One full transaction from a single requester, with rsp_ready held high.
    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        rsp_ready = 1'b1;
        drive(v.req, v.op, v.a, v.b);
        #1;
        chk("ready", {31'd0, v.req ? r1_ready : r0_ready}, 32'd1);
        step();
        r0_valid = 1'b0; r1_valid = 1'b0;
        #1;
        chk("alu_control", {27'd0, alu_control}, {27'd0, v.op});
        chk("alu_a", alu_a, v.a);
        chk("alu_b", alu_b, v.b);
        chk("issue_busy", {31'd0, busy}, 32'd1);
        chk("issue_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, v.req});
        chk("rsp_result", rsp_result, v.res);
        chk("rsp_flag", {31'd0, rsp_flag}, {31'd0, v.flag});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.err});
        step();
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        $display("vec %0d: req=%0d op=%0d a=%h b=%h -> res=%h flag=%0d err=%0d",
                 idx, v.req, v.op, v.a, v.b, v.res, v.flag, v.err);
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd0,  32'd10,         32'd15,         32'h00000019, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 5'd1,  32'd15,         32'd10,         32'h00000005, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 5'd3,  32'hFFFFFFF3,   32'd4,          32'h00000001, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 5'd4,  32'hAAAAAAAA,   32'hFFFF0000,   32'h5555AAAA, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 5'd24, 32'h00000012,   32'h00000034,   32'h00000000, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 5'd16, 32'h00100000,   32'h00000020,   32'h00100000, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 5'd0,  32'hFFFFFFFF,   32'h00000001,   32'h00000000, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 5'd2,  32'hF0F0F0F0,   32'h0FF0FF00,   32'h00F0F000, 1'b0, 1'b0};

        rst = 1'b1; rsp_ready = 1'b0;
        r0_valid = 1'b0; r0_op = '0; r0_a = '0; r0_b = '0;
        r1_valid = 1'b0; r1_op = '0; r1_a = '0; r1_b = '0;

        // Reset held for two cycles with no requests.
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_alu", {27'd0, alu_control} | alu_a | alu_b, 32'd0);
        chk("rst_rsp", rsp_result | {31'd0, rsp_id} | {31'd0, rsp_flag} | {31'd0, rsp_err}, 32'd0);
        r0_valid = 1'b1;
        #1;
        chk("rst_r0_ready", {31'd0, r0_ready}, 32'd1);
        r0_valid = 1'b0;
        #1;
        $display("reset: done");

        // Table-driven single-requester transactions.
        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        // Tie between both requesters. Requester 1 was served last, so r0 must win.
        rsp_ready = 1'b1;
        drive(1'b0, 5'd1, 32'd15, 32'd10);
        drive(1'b1, 5'd3, 32'hFFFFFFF3, 32'd4);
        #1;
        chk("tie_r0_ready", {31'd0, r0_ready}, 32'd1);
        chk("tie_r1_ready", {31'd0, r1_ready}, 32'd0);
        step();
        r0_valid = 1'b0;
        #1;
        chk("tie_issue_r1_ready", {31'd0, r1_ready}, 32'd0);
        step();
        chk("tie_rsp1_id", {31'd0, rsp_id}, 32'd0);
        chk("tie_rsp1_res", rsp_result, 32'h5);
        step();
        chk("tie_r1_ready2", {31'd0, r1_ready}, 32'd1);
        step();
        r1_valid = 1'b0;
        step();
        chk("tie_rsp2_id", {31'd0, rsp_id}, 32'd1);
        chk("tie_rsp2_flag", {31'd0, rsp_flag}, 32'd1);
        step();
        drive(1'b0, 5'd0, 32'd1, 32'd1);
        drive(1'b1, 5'd0, 32'd2, 32'd2);
        #1;
        chk("tie2_r0_ready", {31'd0, r0_ready}, 32'd1);
        chk("tie2_r1_ready", {31'd0, r1_ready}, 32'd0);
        r0_valid = 1'b0; r1_valid = 1'b0;
        #1;
        $display("tie: round-robin sequence done");

        // Backpressure on the response channel.
        rsp_ready = 1'b0;
        drive(1'b1, 5'd4, 32'hAAAAAAAA, 32'hFFFF0000);
        step();
        r1_valid = 1'b0;
        drive(1'b0, 5'd0, 32'd1, 32'd2);
        step();
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_result", rsp_result, 32'h5555AAAA);
            chk("bp_r0_ready", {31'd0, r0_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_idle_r0_ready", {31'd0, r0_ready}, 32'd1);
        step();
        r0_valid = 1'b0;
        step();
        chk("bp_next_id", {31'd0, rsp_id}, 32'd0);
        chk("bp_next_res", rsp_result, 32'd3);
        step();
        $display("backpressure: done");

        // Reset asserted while the op is in ISSUE.
        drive(1'b0, 5'd0, 32'd7, 32'd7);
        step();
        r0_valid = 1'b0;
        drive(1'b1, 5'd0, 32'd5, 32'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_alu_a", alu_a, 32'd0);
        chk("abort_r1_ready", {31'd0, r1_ready}, 32'd1);
        r0_valid = 1'b1;
        #1;
        chk("abort_tie_r0", {31'd0, r0_ready}, 32'd1);
        r0_valid = 1'b0;
        #1;
        step();
        r1_valid = 1'b0;
        step();
        chk("abort_next_id", {31'd0, rsp_id}, 32'd1);
        chk("abort_next_res", rsp_result, 32'd11);
        step();
        $display("reset-in-issue: done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
